// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: five-stage MIPS pipeline control (decode, ID/EX-EX/MEM-MEM/WB control bundle, stall/flush).
// Define PIPE_CTRL_FWD_EN to add the EX-stage forwarding unit; otherwise RAW hazards are resolved by stalling.
module pipe_ctrl_unit #(
    parameter int         RA_W    = 5,
    parameter logic [5:0] OP_RTYP = 6'h00,
    parameter logic [5:0] OP_LW   = 6'h23,
    parameter logic [5:0] OP_SW   = 6'h2B,
    parameter logic [5:0] OP_BEQ  = 6'h04,
    parameter logic [5:0] OP_J    = 6'h02
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      id_opcode,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic            id_jump,
    output logic            pc_hold,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            ex_alu_src,
    output logic [1:0]      ex_alu_op,
    output logic            ex_branch,
    output logic            br_taken,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_reg_write,
    output logic            wb_mem2reg,
    output logic [RA_W-1:0] wb_dest,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            illegal_op
);

    logic            w_reg_dst, w_alu_src, w_branch, w_mem_read, w_mem_write;
    logic            w_reg_write, w_mem2reg, w_illegal, w_rs_used, w_rt_used, w_is_jump;
    logic [1:0]      w_alu_op;
    logic [RA_W-1:0] w_dest;

    always_comb begin
        w_reg_dst   = 1'b0;
        w_alu_src   = 1'b0;
        w_alu_op    = 2'b00;
        w_branch    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_mem2reg   = 1'b0;
        w_illegal   = 1'b0;
        w_rs_used   = 1'b0;
        w_rt_used   = 1'b0;
        w_is_jump   = 1'b0;
        case (id_opcode)
            OP_RTYP: begin
                w_reg_dst   = 1'b1;
                w_alu_op    = 2'b10;
                w_reg_write = 1'b1;
                w_rs_used   = 1'b1;
                w_rt_used   = 1'b1;
            end
            OP_LW: begin
                w_alu_src   = 1'b1;
                w_mem_read  = 1'b1;
                w_mem2reg   = 1'b1;
                w_reg_write = 1'b1;
                w_rs_used   = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_rs_used   = 1'b1;
                w_rt_used   = 1'b1;
            end
            OP_BEQ: begin
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_rs_used   = 1'b1;
                w_rt_used   = 1'b1;
            end
            OP_J:    w_is_jump = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_dest = w_reg_dst ? id_rd : id_rt;

    logic            r_ex_alu_src, r_ex_branch, r_ex_mem_read, r_ex_mem_write;
    logic            r_ex_reg_write, r_ex_mem2reg, r_ex_illegal;
    logic [1:0]      r_ex_alu_op;
    logic [RA_W-1:0] r_ex_dest;
    logic            r_mem_mem_read, r_mem_mem_write, r_mem_reg_write, r_mem_mem2reg;
    logic [RA_W-1:0] r_mem_dest;
    logic            r_wb_reg_write, r_wb_mem2reg;
    logic [RA_W-1:0] r_wb_dest;

    // Register 0 is never a hazard source, so every match requires dest != 0.
    logic w_idex_match, w_exmem_match, w_load_use, w_hazard;
    logic w_br_taken, w_stall, w_bubble;

    assign w_idex_match  = (r_ex_dest != '0) &&
                           ((w_rs_used && (r_ex_dest == id_rs)) || (w_rt_used && (r_ex_dest == id_rt)));
    assign w_exmem_match = (r_mem_dest != '0) &&
                           ((w_rs_used && (r_mem_dest == id_rs)) || (w_rt_used && (r_mem_dest == id_rt)));
    assign w_load_use    = r_ex_mem_read && w_idex_match;

`ifdef PIPE_CTRL_FWD_EN
    assign w_hazard = w_load_use;
`else
    assign w_hazard = w_load_use || (r_ex_reg_write && w_idex_match) || (r_mem_reg_write && w_exmem_match);
`endif

    // A taken branch wins over a stall so the PC can load the branch target.
    assign w_br_taken = r_ex_branch && ex_zero;
    assign w_stall    = w_hazard && !w_br_taken;
    assign w_bubble   = w_stall || w_br_taken;

    assign id_jump    = w_is_jump && !w_br_taken && rst_n;
    assign br_taken   = w_br_taken;
    assign pc_hold    = w_stall;
    assign ifid_hold  = w_stall;
    assign ifid_flush = w_br_taken || id_jump;

`ifdef PIPE_CTRL_FWD_EN
    logic [RA_W-1:0] r_ex_rs, r_ex_rt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_alu_src    <= 1'b0;
            r_ex_alu_op     <= 2'b00;
            r_ex_branch     <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem2reg    <= 1'b0;
            r_ex_dest       <= '0;
            r_ex_illegal    <= 1'b0;
`ifdef PIPE_CTRL_FWD_EN
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
`endif
            r_mem_mem_read  <= 1'b0;
            r_mem_mem_write <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem2reg   <= 1'b0;
            r_mem_dest      <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem2reg    <= 1'b0;
            r_wb_dest       <= '0;
        end else begin
            r_ex_alu_src    <= w_bubble ? 1'b0  : w_alu_src;
            r_ex_alu_op     <= w_bubble ? 2'b00 : w_alu_op;
            r_ex_branch     <= w_bubble ? 1'b0  : w_branch;
            r_ex_mem_read   <= w_bubble ? 1'b0  : w_mem_read;
            r_ex_mem_write  <= w_bubble ? 1'b0  : w_mem_write;
            r_ex_reg_write  <= w_bubble ? 1'b0  : w_reg_write;
            r_ex_mem2reg    <= w_bubble ? 1'b0  : w_mem2reg;
            r_ex_dest       <= w_bubble ? '0    : w_dest;
            r_ex_illegal    <= w_bubble ? 1'b0  : w_illegal;
`ifdef PIPE_CTRL_FWD_EN
            // Unused source fields are zeroed so they can never pick up a forward.
            r_ex_rs         <= (w_bubble || !w_rs_used) ? '0 : id_rs;
            r_ex_rt         <= (w_bubble || !w_rt_used) ? '0 : id_rt;
`endif
            r_mem_mem_read  <= r_ex_mem_read;
            r_mem_mem_write <= r_ex_mem_write;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem2reg   <= r_ex_mem2reg;
            r_mem_dest      <= r_ex_dest;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem2reg    <= r_mem_mem2reg;
            r_wb_dest       <= r_mem_dest;
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    logic w_mem_fwd_ok, w_wb_fwd_ok;
    assign w_mem_fwd_ok = r_mem_reg_write && (r_mem_dest != '0);
    assign w_wb_fwd_ok  = r_wb_reg_write && (r_wb_dest != '0);
    // EX/MEM holds the younger result, so it takes priority over MEM/WB.
    assign fwd_a = (w_mem_fwd_ok && (r_mem_dest == r_ex_rs)) ? 2'b10 :
                   (w_wb_fwd_ok  && (r_wb_dest  == r_ex_rs)) ? 2'b01 : 2'b00;
    assign fwd_b = (w_mem_fwd_ok && (r_mem_dest == r_ex_rt)) ? 2'b10 :
                   (w_wb_fwd_ok  && (r_wb_dest  == r_ex_rt)) ? 2'b01 : 2'b00;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign ex_alu_src   = r_ex_alu_src;
    assign ex_alu_op    = r_ex_alu_op;
    assign ex_branch    = r_ex_branch;
    assign illegal_op   = r_ex_illegal;
    assign mem_read     = r_mem_mem_read;
    assign mem_write    = r_mem_mem_write;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_mem2reg   = r_wb_mem2reg;
    assign wb_dest      = r_wb_dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: stage-bundle scoreboard plus per-cycle hazard expectations.
// Hazard expectations follow the PIPE_CTRL_FWD_EN build selection.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BAD = 6'h3F;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem2reg;
        logic [4:0] dest;
        logic       illegal;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_zero = 1'b0;
    logic       id_jump, pc_hold, ifid_hold, ifid_flush, ex_alu_src, ex_branch, br_taken;
    logic       mem_read, mem_write, wb_reg_write, wb_mem2reg, illegal_op;
    logic [1:0] ex_alu_op, fwd_a, fwd_b;
    logic [4:0] wb_dest;
    logic [22:0] all_out;

    int total = 0;
    int bad   = 0;
    bundle_t ex_q[$], mem_q[$], wb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_zero(ex_zero), .id_jump(id_jump), .pc_hold(pc_hold),
        .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .br_taken(br_taken),
        .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem2reg(wb_mem2reg), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .illegal_op(illegal_op)
    );

    assign all_out = {id_jump, pc_hold, ifid_hold, ifid_flush, ex_alu_src, ex_alu_op, ex_branch,
                      br_taken, mem_read, mem_write, wb_reg_write, wb_mem2reg, wb_dest,
                      fwd_a, fwd_b, illegal_op};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        bundle_t b;
        b = '0;
        case (op)
            OP_R:   begin b.alu_op = 2'b10; b.reg_write = 1'b1; b.dest = rd; end
            OP_LW:  begin b.alu_src = 1'b1; b.mem_read = 1'b1; b.mem2reg = 1'b1;
                          b.reg_write = 1'b1; b.dest = rt; end
            OP_SW:  begin b.alu_src = 1'b1; b.mem_write = 1'b1; b.dest = rt; end
            OP_BEQ: begin b.alu_op = 2'b01; b.branch = 1'b1; b.dest = rt; end
            OP_J:   b.dest = rt;
            default: begin b.illegal = 1'b1; b.dest = rt; end
        endcase
        return b;
    endfunction

    task automatic do_reset();
        id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_val("post_reset.all_out", 32'(all_out), 32'd0);
        ex_q.delete();
        mem_q.delete();
        wb_q.delete();
        mem_q.push_back(bundle_t'(0));
        wb_q.push_back(bundle_t'(0));
    endtask

    // One ID-stage cycle: drive IF/ID, check hazard outputs mid-cycle, then scoreboard the stages after the edge.
    task automatic step(input string name, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic zero,
                        input logic bubble, input logic hold, input logic flush,
                        input logic jump, input logic br, input logic [1:0] fa, input logic [1:0] fb);
        bundle_t e, m, w;
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = zero;
        @(negedge clk);
        check_val({name, ".pc_hold"},    32'(pc_hold),    32'(hold));
        check_val({name, ".ifid_hold"},  32'(ifid_hold),  32'(hold));
        check_val({name, ".ifid_flush"}, 32'(ifid_flush), 32'(flush));
        check_val({name, ".id_jump"},    32'(id_jump),    32'(jump));
        check_val({name, ".br_taken"},   32'(br_taken),   32'(br));
        check_val({name, ".fwd_a"},      32'(fwd_a),      32'(fa));
        check_val({name, ".fwd_b"},      32'(fwd_b),      32'(fb));
        $display("step %-8s op=%02h rs=%0d rt=%0d rd=%0d hold=%0d flush=%0d fwd=%b/%b",
                 name, op, rs, rt, rd, pc_hold, ifid_flush, fwd_a, fwd_b);
        ex_q.push_back(bubble ? bundle_t'(0) : decode(op, rt, rd));
        @(posedge clk);
        #1;
        e = ex_q.pop_front();
        m = mem_q.pop_front();
        w = wb_q.pop_front();
        check_val({name, ".ex_alu_src"},   32'(ex_alu_src),   32'(e.alu_src));
        check_val({name, ".ex_alu_op"},    32'(ex_alu_op),    32'(e.alu_op));
        check_val({name, ".ex_branch"},    32'(ex_branch),    32'(e.branch));
        check_val({name, ".illegal_op"},   32'(illegal_op),   32'(e.illegal));
        check_val({name, ".mem_read"},     32'(mem_read),     32'(m.mem_read));
        check_val({name, ".mem_write"},    32'(mem_write),    32'(m.mem_write));
        check_val({name, ".wb_reg_write"}, 32'(wb_reg_write), 32'(w.reg_write));
        check_val({name, ".wb_mem2reg"},   32'(wb_mem2reg),   32'(w.mem2reg));
        check_val({name, ".wb_dest"},      32'(wb_dest),      32'(w.dest));
        mem_q.push_back(e);
        wb_q.push_back(m);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            step("nop", OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset mid-run: LW in EX, J in ID, then asynchronous reset
        step("t1_lw", OP_LW, 1, 8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        id_opcode = OP_J;
        #1 check_val("t1.pre_jump", 32'(id_jump), 32'd1);
        check_val("t1.pre_alu_src", 32'(ex_alu_src), 32'd1);
        rst_n = 1'b0;
        #1 check_val("t1.async_all_out", 32'(all_out), 32'd0);
        do_reset();
        nops(2);

        // Load-use: LW $8 ; ADD $9,$8,$1
        do_reset();
        step("t2_lw", OP_LW, 1, 8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t2_add", OP_R, 8, 1, 9, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
`ifdef PIPE_CTRL_FWD_EN
        step("t2_add", OP_R, 8, 1, 9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t2_nop", OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00);
`else
        step("t2_add", OP_R, 8, 1, 9, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t2_add", OP_R, 8, 1, 9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t2_nop", OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
`endif
        nops(2);

        // RAW: ADD $3,$1,$2 ; SUB $4,$3,$3
        do_reset();
        step("t3_add", OP_R, 1, 2, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
`ifdef PIPE_CTRL_FWD_EN
        step("t3_sub", OP_R, 3, 3, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t3_nop", OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10);
`else
        step("t3_sub", OP_R, 3, 3, 4, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t3_sub", OP_R, 3, 3, 4, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t3_sub", OP_R, 3, 3, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t3_nop", OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
`endif
        nops(3);

        // BEQ taken in EX while ID holds a consumer of the earlier load
        do_reset();
        step("t4_lw", OP_LW, 1, 8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t4_beq", OP_BEQ, 1, 2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t4_add", OP_R, 8, 1, 9, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        nops(3);

        // Jump, then a jump masked by a taken branch
        do_reset();
        step("t5_j", OP_J, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        step("t5_sw", OP_SW, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t5_beq", OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t5_jmsk", OP_J, 0, 0, 0, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        nops(3);

        // Illegal opcode, then writes/reads of register 0
        do_reset();
        step("t6_bad", OP_BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t6_add0", OP_R, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t6_add5", OP_R, 0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        nops(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
